// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Write-back bus between the two producers (A: ALU, B: load return),
//   decode's issue port, and the register array.
//   Signals:
//     a_valid/a_ready/a_rd/a_data  producer A handshake + payload
//     b_valid/b_ready/b_rd/b_data  producer B handshake + payload
//     issue_valid/issue_rd         decode marks a destination outstanding
//     busy                         pending-write scoreboard (bit i = ri)
//     G                            registered write data to the array
//     R_in                         registered one-hot write enable
//   Modports: master = producers/decode/array side, slave = arbiter.
interface regfile_wb_arbiter_if #(
   parameter int XLEN = 36,
   parameter int NREG = 32
);
   localparam int RW = $clog2(NREG);

   logic            a_valid;
   logic            a_ready;
   logic [RW-1:0]   a_rd;
   logic [XLEN:0]   a_data;
   logic            b_valid;
   logic            b_ready;
   logic [RW-1:0]   b_rd;
   logic [XLEN:0]   b_data;
   logic            issue_valid;
   logic [RW-1:0]   issue_rd;
   logic [NREG-1:0] busy;
   logic [XLEN:0]   G;
   logic [NREG-1:0] R_in;

   modport master (
      output a_valid, a_rd, a_data,
      output b_valid, b_rd, b_data,
      output issue_valid, issue_rd,
      input  a_ready, b_ready, busy, G, R_in
   );

   modport slave (
      input  a_valid, a_rd, a_data,
      input  b_valid, b_rd, b_data,
      input  issue_valid, issue_rd,
      output a_ready, b_ready, busy, G, R_in
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register array's single write bus (G / R_in) between two
//   write-back producers with round-robin arbitration, and keeps the
//   pending-write scoreboard that decode uses for hazard checks.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     wb     regfile_wb_arbiter_if.slave (handshakes, issue, busy, G, R_in)
//   Timing: transfer at edge N -> G/R_in valid in cycle N+1; busy clear
//   visible from cycle N+1. One write per cycle sustained.
module regfile_wb_arbiter #(
   parameter int XLEN = 36,
   parameter int NREG = 32
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave wb
);
   localparam int RW = $clog2(NREG);

   logic            last_b;      // 1: B won the most recent transfer
   logic            grant_a;
   logic            grant_b;
   logic            xfer;
   logic [RW-1:0]   win_rd;
   logic [XLEN:0]   win_data;
   logic [NREG-1:0] win_dec;     // one-hot of win_rd, r0 excluded
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_nxt;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] r_in_q;
   logic [XLEN:0]   g_q;

   // Grant depends only on valids and the pointer. Held low in reset so a
   // producer never sees a handshake the core did not take.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset) begin
         if (wb.a_valid && wb.b_valid) begin
            grant_a = last_b;
            grant_b = !last_b;
         end else begin
            grant_a = wb.a_valid;
            grant_b = wb.b_valid;
         end
      end
   end

   assign xfer     = grant_a || grant_b;
   assign win_rd   = grant_b ? wb.b_rd   : wb.a_rd;
   assign win_data = grant_b ? wb.b_data : wb.a_data;

   // Per-register decode for the write enable and scoreboard set/clear.
   // Index 0 is hard-wired off so r0 writes complete without any enable.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      if (i == 0) begin : g_r0
         assign win_dec[i] = 1'b0;
         assign set_vec[i] = 1'b0;
      end else begin : g_rn
         assign win_dec[i] = (win_rd == RW'(i));
         assign set_vec[i] = wb.issue_valid && (wb.issue_rd == RW'(i));
      end
   end

   assign clr_vec  = xfer ? win_dec : '0;
   // Set after clear: a same-index set belongs to a newer instruction.
   assign busy_nxt = (busy_q & ~clr_vec) | set_vec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_b <= 1'b1;
         g_q    <= '0;
         r_in_q <= '0;
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         if (xfer) begin
            last_b <= grant_b;
            g_q    <= win_data;
            r_in_q <= win_dec;
         end else begin
            r_in_q <= '0;
         end
      end
   end

   assign wb.a_ready = grant_a;
   assign wb.b_ready = grant_b;
   assign wb.busy    = busy_q;
   assign wb.G       = g_q;
   assign wb.R_in    = r_in_q;

   // The array must never see two enables at once.
   a_r_in_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(r_in_q));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
   localparam int XLEN = 36;
   localparam int NREG = 32;

   typedef struct {
      logic            av;
      logic [4:0]      ard;
      logic [XLEN:0]   adat;
      logic            bv;
      logic [4:0]      brd;
      logic [XLEN:0]   bdat;
      logic            iv;
      logic [4:0]      ird;
      logic            ea;
      logic            eb;
      logic [NREG-1:0] ebusy;   // busy expected after this edge
   } vec_t;

   typedef struct {
      logic [NREG-1:0] r;
      logic [XLEN:0]   g;
   } out_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   out_t exp_q[$];
   logic [XLEN:0] g_model = '0;
   vec_t vecs[17];

   localparam logic [XLEN:0] D3 = 37'h0A_1111_0003;
   localparam logic [XLEN:0] D4 = 37'h15_2222_0004;
   localparam logic [XLEN:0] D5 = 37'h01_2345_6789;
   localparam logic [XLEN:0] DF = 37'h1F_FFFF_FFFF;
   localparam logic [XLEN:0] D7 = 37'h00_0000_0777;
   localparam logic [XLEN:0] D9 = 37'h10_9999_0009;
   localparam logic [XLEN:0] DC = 37'h0C_CCCC_000C;
   localparam logic [XLEN:0] DE = 37'h03_0303_001E;

   regfile_wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) wb();
   regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (.clk(clk), .reset(reset), .wb(wb));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [XLEN:0] adat,
                               input logic bv, input logic [4:0] brd, input logic [XLEN:0] bdat,
                               input logic iv, input logic [4:0] ird,
                               input logic ea, input logic eb, input logic [NREG-1:0] ebusy);
      vec_t v;
      v.av = av; v.ard = ard; v.adat = adat;
      v.bv = bv; v.brd = brd; v.bdat = bdat;
      v.iv = iv; v.ird = ird;
      v.ea = ea; v.eb = eb; v.ebusy = ebusy;
      return v;
   endfunction

   function automatic logic [NREG-1:0] onehot(input logic [4:0] rd);
      logic [NREG-1:0] r;
      r = 32'd1 << rd;
      r[0] = 1'b0;
      return r;
   endfunction

   task automatic drive_idle();
      wb.a_valid = 0; wb.a_rd = '0; wb.a_data = '0;
      wb.b_valid = 0; wb.b_rd = '0; wb.b_data = '0;
      wb.issue_valid = 0; wb.issue_rd = '0;
   endtask

   // Called 1 time unit after a rising edge: drive, check readies, push the
   // expected array write, cross the edge, then pop and compare.
   task automatic apply(input int idx, input vec_t v);
      out_t e;
      out_t got;
      wb.a_valid = v.av; wb.a_rd = v.ard; wb.a_data = v.adat;
      wb.b_valid = v.bv; wb.b_rd = v.brd; wb.b_data = v.bdat;
      wb.issue_valid = v.iv; wb.issue_rd = v.ird;
      #2;
      chk($sformatf("v%0d_a_ready", idx), 64'(wb.a_ready), 64'(v.ea));
      chk($sformatf("v%0d_b_ready", idx), 64'(wb.b_ready), 64'(v.eb));
      if (v.ea) begin
         e.r = onehot(v.ard); e.g = v.adat;
      end else if (v.eb) begin
         e.r = onehot(v.brd); e.g = v.bdat;
      end else begin
         e.r = '0; e.g = g_model;
      end
      g_model = e.g;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk($sformatf("v%0d_queue_empty", idx), 64'd1, 64'd0);
      end else begin
         got = exp_q.pop_front();
         chk($sformatf("v%0d_R_in", idx), 64'(wb.R_in), 64'(got.r));
         chk($sformatf("v%0d_G", idx), 64'(wb.G), 64'(got.g));
      end
      chk($sformatf("v%0d_busy", idx), 64'(wb.busy), 64'(v.ebusy));
   endtask

   initial begin
      //              A: v rd  data   B: v rd  data   iss v rd   exp a b  busy
      vecs[0]  = mk(0, 0,  '0,  0, 0,  '0,  0, 0,  0, 0, 32'h0);
      vecs[1]  = mk(1, 3,  D3,  1, 4,  D4,  0, 0,  1, 0, 32'h0);  // first contention: A
      vecs[2]  = mk(1, 3,  D3,  1, 4,  D4,  0, 0,  0, 1, 32'h0);
      vecs[3]  = mk(1, 3,  D3,  1, 4,  D4,  0, 0,  1, 0, 32'h0);
      vecs[4]  = mk(1, 3,  D3,  1, 4,  D4,  0, 0,  0, 1, 32'h0);
      vecs[5]  = mk(0, 0,  '0,  0, 0,  '0,  0, 0,  0, 0, 32'h0);
      vecs[6]  = mk(1, 5,  D5,  0, 0,  '0,  0, 0,  1, 0, 32'h0);
      vecs[7]  = mk(0, 0,  '0,  0, 0,  '0,  0, 0,  0, 0, 32'h0);  // G holds
      vecs[8]  = mk(0, 0,  '0,  1, 0,  DF,  0, 0,  0, 1, 32'h0);  // r0 write
      vecs[9]  = mk(0, 0,  '0,  0, 0,  '0,  1, 7,  0, 0, 32'h80);
      vecs[10] = mk(1, 7,  D7,  0, 0,  '0,  0, 0,  1, 0, 32'h0);
      vecs[11] = mk(0, 0,  '0,  0, 0,  '0,  1, 9,  0, 0, 32'h200);
      vecs[12] = mk(0, 0,  '0,  1, 9,  D9,  1, 9,  0, 1, 32'h200); // set wins
      vecs[13] = mk(1, 9,  D9,  0, 0,  '0,  1, 12, 1, 0, 32'h1000);
      vecs[14] = mk(0, 0,  '0,  0, 0,  '0,  1, 0,  0, 0, 32'h1000); // issue r0 ignored
      vecs[15] = mk(1, 12, DC,  1, 30, DE,  0, 0,  0, 1, 32'h1000); // A was last: B
      vecs[16] = mk(1, 12, DC,  0, 0,  '0,  0, 0,  1, 0, 32'h0);

      // Reset state, with both producers requesting.
      drive_idle();
      wb.a_valid = 1; wb.b_valid = 1;
      #12;
      chk("rst_a_ready", 64'(wb.a_ready), 64'd0);
      chk("rst_b_ready", 64'(wb.b_ready), 64'd0);
      chk("rst_R_in", 64'(wb.R_in), 64'd0);
      chk("rst_G", 64'(wb.G), 64'd0);
      chk("rst_busy", 64'(wb.busy), 64'd0);
      drive_idle();
      #2 reset = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) apply(i, vecs[i]);

      // Reset mid-operation: fill busy with r8..r11, then a transfer to r2.
      for (int i = 8; i < 12; i++) begin
         drive_idle();
         wb.issue_valid = 1; wb.issue_rd = 5'(i);
         @(posedge clk);
         #1;
      end
      drive_idle();
      chk("pre_rst_busy", 64'(wb.busy), 64'h0F00);
      wb.a_valid = 1; wb.a_rd = 5'd2; wb.a_data = D5;
      @(posedge clk);           // edge N
      #1;
      chk("pre_rst_R_in", 64'(wb.R_in), 64'h4);
      wb.b_valid = 1; wb.b_rd = 5'd6; wb.b_data = D4;
      #1 reset = 1;
      #1;
      chk("async_R_in", 64'(wb.R_in), 64'd0);
      chk("async_G", 64'(wb.G), 64'd0);
      chk("async_busy", 64'(wb.busy), 64'd0);
      chk("async_a_ready", 64'(wb.a_ready), 64'd0);
      chk("async_b_ready", 64'(wb.b_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("held_R_in", 64'(wb.R_in), 64'd0);
      reset = 0;
      #1;
      chk("post_rst_a_ready", 64'(wb.a_ready), 64'd1);
      chk("post_rst_b_ready", 64'(wb.b_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("post_rst_R_in", 64'(wb.R_in), 64'h4);
      chk("post_rst_G", 64'(wb.G), 64'(D5));
      drive_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
